// File: rtl/dmem_ctrl.sv
// Data-memory controller: RV32I sub-word load/store, SB/SH read-modify-write, loader arbitration.
// Latency: loads 0 cycles, SW/loader writes commit next edge, SB/SH take 2 cycles (stall, then merge).
// Backpressure: c_stall holds the MEM stage; the losing or waiting loader sees l_gnt=0 and keeps l_req.
module dmem_ctrl #(
  parameter bit LOADER_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [2:0]  c_funct3,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  output logic        c_misalign,
  input  logic        l_req,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic [31:0] m_a,
  output logic [31:0] m_wd,
  output logic        m_we,
  input  logic [31:0] m_rd
);

  typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_addr_q, hold_addr_d;
  logic [31:0] hold_word_q, hold_word_d;
  logic [15:0] hold_data_q, hold_data_d;
  logic        hold_half_q, hold_half_d;

  logic        core_win;
  logic        misalign;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] merged;

  assign core_win = c_req && !(l_req && LOADER_PRIO);
  assign ld_byte  = m_rd[{c_addr[1:0], 3'b000} +: 8];
  assign ld_half  = m_rd[{c_addr[1], 4'b0000} +: 16];

  // Alignment by access size; undefined store widths are never flagged.
  always_comb begin
    misalign = 1'b0;
    case (c_funct3)
      3'b001:  misalign = c_addr[0];
      3'b101:  misalign = !c_we && c_addr[0];
      3'b010:  misalign = (c_addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
  end

  // Replace the addressed byte or half of the captured RAM word.
  always_comb begin
    merged = hold_word_q;
    if (hold_half_q) begin
      merged[{hold_addr_q[1], 4'b0000} +: 16] = hold_data_q;
    end else begin
      merged[{hold_addr_q[1:0], 3'b000} +: 8] = hold_data_q[7:0];
    end
  end

  // Output decode and next-state; everything stays quiet while reset is low.
  always_comb begin
    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    hold_word_d = hold_word_q;
    hold_data_d = hold_data_q;
    hold_half_d = hold_half_q;
    m_a         = c_addr;
    m_wd        = c_wdata;
    m_we        = 1'b0;
    l_gnt       = 1'b0;
    c_stall     = 1'b0;
    c_misalign  = 1'b0;
    c_rdata     = 32'h0;
    if (reset) begin
      if (state_q == MERGE) begin
        m_a     = hold_addr_q;
        m_wd    = merged;
        m_we    = 1'b1;
        state_d = IDLE;
      end else if (l_req && !core_win) begin
        m_a     = l_addr;
        m_wd    = l_wdata;
        m_we    = 1'b1;
        l_gnt   = 1'b1;
        c_stall = c_req;
      end else if (core_win) begin
        if (misalign) begin
          c_misalign = 1'b1;
        end else if (c_we) begin
          case (c_funct3)
            3'b010: m_we = 1'b1;
            3'b000, 3'b001: begin
              c_stall     = 1'b1;
              hold_addr_d = c_addr;
              hold_word_d = m_rd;
              hold_data_d = c_wdata[15:0];
              hold_half_d = c_funct3[0];
              state_d     = MERGE;
            end
            default: m_we = 1'b0;
          endcase
        end else begin
          case (c_funct3)
            3'b000:  c_rdata = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  c_rdata = {24'h0, ld_byte};
            3'b001:  c_rdata = {{16{ld_half[15]}}, ld_half};
            3'b101:  c_rdata = {16'h0, ld_half};
            3'b010:  c_rdata = m_rd;
            default: c_rdata = 32'h0;
          endcase
        end
      end
    end
  end

  // State and hold registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_addr_q <= 32'h0;
      hold_word_q <= 32'h0;
      hold_data_q <= 16'h0;
      hold_half_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_addr_q <= hold_addr_d;
      hold_word_q <= hold_word_d;
      hold_data_q <= hold_data_d;
      hold_half_q <= hold_half_d;
    end
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between the MEM stage, a word-wide asynchronous-read data RAM and a program/data loader port. Handles RV32I sub-word access: load extraction with sign/zero extension, and SB/SH as a two-cycle read-modify-write. Arbitrates RAM ownership between the core and the loader, and flags misaligned accesses.

## Interface
- LOADER_PRIO, 1: 1 = loader wins simultaneous requests in IDLE; 0 = core wins.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- c_req  in  1  core memory access valid (load or store).
- c_we  in  1  core access is a store.
- c_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- c_addr  in  32  core byte address.
- c_wdata  in  32  core store data (rs2, low bytes used for SB/SH).
- c_rdata  out  32  extended load result.
- c_stall  out  1  hold MEM stage, keep c_* stable.
- c_misalign  out  1  current core access is misaligned; dropped.
- l_req  in  1  loader word-write request.
- l_addr  in  32  loader byte address (bits [1:0] ignored).
- l_wdata  in  32  loader write word.
- l_gnt  out  1  loader write performed this cycle.
- m_a  out  32  RAM byte address (RAM indexes a[31:2]).
- m_wd  out  32  RAM write word.
- m_we  out  1  RAM write enable, sampled on posedge clk.
- m_rd  in  32  RAM asynchronous read word at m_a.

## Operation
- States: IDLE, MERGE. Registers: state, hold_addr, hold_word (old RAM word), hold_data, hold_f3.
- Misalignment: H/HU with addr[0]=1; W with addr[1:0]≠0. In IDLE, c_req with misalignment → c_misalign=1, m_we=0, c_rdata=0, c_stall=0, no state change.
- Arbitration in IDLE, both valid: LOADER_PRIO selects the winner. The loser is held: if core → c_stall=1; if loader → l_gnt=0.
- Loader grant (IDLE): m_a=l_addr, m_wd=l_wdata, m_we=1, l_gnt=1; stay IDLE.
- Core load (IDLE): m_a=c_addr, m_we=0; c_rdata extracts m_rd byte lane addr[1:0] (B/BU) or half lane addr[1] (H/HU). Sign-extend B/H, zero-extend BU/HU, W passes through. Single cycle, c_stall=0.
- Core SW (IDLE): m_a=c_addr, m_wd=c_wdata, m_we=1, single cycle, c_stall=0.
- Core SB/SH (IDLE): m_a=c_addr, m_we=0, c_stall=1. Capture m_rd→hold_word, c_addr/c_wdata/funct3 into hold regs. Go to MERGE.
- MERGE: m_a=hold_addr; m_wd=hold_word with the addressed byte replaced by hold_data[7:0] (SB) or half by hold_data[15:0] (SH); m_we=1, c_stall=0, l_gnt=0 (loader waits); next state IDLE. Live c_* are ignored in MERGE because they still show the same instruction.
- c_req=0 and l_req=0 in IDLE: m_we=0, c_stall=0, c_rdata=0.
- Store funct3 values other than 000/001/010: treated as no-op, c_misalign=0.

## Timing
- Reset (reset=0 at posedge): state→IDLE, hold regs→0. While reset=0: m_we=0, l_gnt=0, c_stall=0, c_misalign=0, c_rdata=0. Reset during MERGE aborts the write, and RAM stays unchanged.
- All outputs are combinational from state, hold regs and inputs. Only the state and hold regs are flopped.
- Load latency 0 cycles (same-cycle c_rdata). SW and loader write: commit at the next posedge.
- SB/SH: 2 cycles. Cycle 1 has c_stall=1 and the RAM is read. Cycle 2 has c_stall=0, and the merged word commits at the posedge ending cycle 2.
- A loader request arriving during MERGE is granted in the following IDLE cycle, subject to priority.
- A load in the cycle after MERGE to the same word sees the merged data.

## Test plan
- Reset: hold reset=0 for 2 cycles with c_req=1, l_req=1 → m_we=0, l_gnt=0, c_stall=0, c_rdata=0.
- Loader: write 0x8899AABC to addr 0x10. Core LB 0x10 → 0xFFFFFFBC; LBU 0x11 → 0x000000AA; LH 0x12 → 0xFFFF8899; LHU 0x10 → 0x0000AABC; LW 0x10 → 0x8899AABC.
- Starting from word 0x8899AABC at 0x10: SB 0x13 data 0x12345677 → c_stall=1 for exactly one cycle, then word reads 0x7799AABC. SH 0x10 data 0x0000BEEF → 0x7799BEEF.
- Misaligned: LW 0x12, SH 0x11 → c_misalign=1 in the same cycle, m_we=0, word at 0x10 unchanged.
- Arbitration: with LOADER_PRIO=1, same-cycle c_req SW and l_req → l_gnt=1, c_stall=1, and the core SW completes next cycle. l_req raised during MERGE → l_gnt=0 that cycle, granted the next.
- Reset asserted in the MERGE cycle of SB 0x20 → RAM word at 0x20 unchanged, state IDLE after release.
